// File: rtl/point_judge_stream.sv
// rtl/point_judge_stream.sv - edge-interval judge: segments edge intervals into symbol counts and streams them
module point_judge_stream #(
    parameter int ASK_WIDTH = 16,
    parameter int CNT_WIDTH = 12,
    parameter int MAX_KEEP  = 4,
    parameter int WARMUP    = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 de_enable,
    input  logic                 flag_edg_rise,
    input  logic                 flag_edg_fall,
    input  logic [ASK_WIDTH-1:0] threshold_peak,
    input  logic [CNT_WIDTH-1:0] cnt_point_ptr,
    input  logic                 wave_ready,
    output logic                 edg_enable,
    output logic                 edg_invalid,
    output logic                 wave_valid,
    output logic                 wave_value,
    output logic                 sym_overflow,
    output logic                 seg_drop,
    output logic                 busy
);
    localparam int DW = CNT_WIDTH + 1;
    localparam int WW = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);
    localparam int IW = $clog2(DW + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;

    logic [WW-1:0]        warm_cnt;
    logic                 last_rise;
    logic [CNT_WIDTH-1:0] cnt;
    logic [ASK_WIDTH-1:0] peak_reg;

    logic                 pend_full;
    logic [CNT_WIDTH-1:0] pend_len;
    logic                 pend_level;

    div_state_t           div_state;
    logic [DW-1:0]        quo;
    logic [CNT_WIDTH-1:0] rem;
    logic [CNT_WIDTH-1:0] dvs;
    logic                 div_level;
    logic [IW-1:0]        it_cnt;

    logic [3:0]           em_left;

    logic edge_one, edge_both, seg_close;
    logic [CNT_WIDTH-1:0] cnt_inc, seg_len;
    assign edge_one  = de_enable & (flag_edg_rise ^ flag_edg_fall);
    assign edge_both = de_enable & flag_edg_rise & flag_edg_fall;
    assign seg_close = edge_one & edg_enable & (flag_edg_rise != last_rise);
    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    // cnt counts clocks since the accepted edge minus one, so the interval is cnt+1
    assign seg_len   = cnt_inc;

    logic div_idle, div_take_pend, div_take_new, pend_store, drop;
    logic [CNT_WIDTH-1:0] load_len;
    logic load_level;
    assign div_idle      = (div_state == DIV_IDLE);
    assign div_take_pend = div_idle & pend_full;
    assign div_take_new  = seg_close & div_idle & ~pend_full;
    assign pend_store    = seg_close & ~div_take_new & (~pend_full | div_take_pend);
    assign drop          = seg_close & ~div_take_new & ~pend_store;
    assign load_len      = div_take_pend ? pend_len : seg_len;
    assign load_level    = div_take_pend ? pend_level : last_rise;

    logic [DW-1:0] trial;
    logic div_ge, q_bad, em_free, hand;
    assign trial   = {rem, quo[DW-1]};
    assign div_ge  = (trial >= {1'b0, dvs});
    assign q_bad   = (dvs == '0) | (quo > DW'(MAX_KEEP));
    assign em_free = ~wave_valid | (wave_ready & (em_left == 4'd1));
    assign hand    = (div_state == DIV_DONE) & ~q_bad & (quo != '0) & em_free;

    assign busy = ~div_idle | pend_full | wave_valid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            warm_cnt    <= '0;
            last_rise   <= 1'b0;
            cnt         <= '0;
            peak_reg    <= '0;
            edg_enable  <= 1'b0;
            edg_invalid <= 1'b0;
        end else if (!de_enable) begin
            warm_cnt    <= '0;
            last_rise   <= 1'b0;
            cnt         <= '0;
            peak_reg    <= '0;
            edg_enable  <= 1'b0;
            edg_invalid <= 1'b0;
        end else begin
            edg_invalid <= edge_both;
            if (edge_one && !edg_enable) begin
                warm_cnt  <= warm_cnt + 1'b1;
                last_rise <= flag_edg_rise;
                cnt       <= '0;
                peak_reg  <= threshold_peak;
                if (warm_cnt == WW'(WARMUP - 1))
                    edg_enable <= 1'b1;
            end else if (edge_one && !seg_close) begin
                // same polarity twice: the interval keeps running across it
                edg_invalid <= 1'b1;
                cnt         <= cnt_inc;
                peak_reg    <= (threshold_peak > peak_reg) ? threshold_peak : peak_reg;
            end else if (seg_close) begin
                last_rise <= flag_edg_rise;
                cnt       <= '0;
                peak_reg  <= threshold_peak;
            end else begin
                cnt <= cnt_inc;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_full  <= 1'b0;
            pend_len   <= '0;
            pend_level <= 1'b0;
            seg_drop   <= 1'b0;
        end else if (!de_enable) begin
            pend_full  <= 1'b0;
            pend_len   <= '0;
            pend_level <= 1'b0;
            seg_drop   <= 1'b0;
        end else begin
            seg_drop <= drop;
            if (pend_store) begin
                pend_full  <= 1'b1;
                pend_len   <= seg_len;
                pend_level <= last_rise;
            end else if (div_take_pend) begin
                pend_full <= 1'b0;
            end
        end
    end

    // restoring divider: quotient bits shift into quo as the dividend shifts out
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_state    <= DIV_IDLE;
            quo          <= '0;
            rem          <= '0;
            dvs          <= '0;
            div_level    <= 1'b0;
            it_cnt       <= '0;
            sym_overflow <= 1'b0;
        end else if (!de_enable) begin
            div_state    <= DIV_IDLE;
            quo          <= '0;
            rem          <= '0;
            dvs          <= '0;
            div_level    <= 1'b0;
            it_cnt       <= '0;
            sym_overflow <= 1'b0;
        end else begin
            sym_overflow <= 1'b0;
            case (div_state)
                DIV_IDLE: begin
                    if (div_take_pend || div_take_new) begin
                        quo       <= {1'b0, load_len} + {2'b0, cnt_point_ptr[CNT_WIDTH-1:1]};
                        rem       <= '0;
                        dvs       <= cnt_point_ptr;
                        div_level <= load_level;
                        it_cnt    <= '0;
                        div_state <= DIV_RUN;
                    end
                end
                DIV_RUN: begin
                    rem    <= div_ge ? CNT_WIDTH'(trial - {1'b0, dvs}) : trial[CNT_WIDTH-1:0];
                    quo    <= {quo[DW-2:0], div_ge};
                    it_cnt <= it_cnt + 1'b1;
                    if (it_cnt == IW'(DW - 1))
                        div_state <= DIV_DONE;
                end
                DIV_DONE: begin
                    if (q_bad) begin
                        sym_overflow <= 1'b1;
                        div_state    <= DIV_IDLE;
                    end else if (quo == '0 || em_free) begin
                        div_state <= DIV_IDLE;
                    end
                end
                default: div_state <= DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wave_valid <= 1'b0;
            wave_value <= 1'b0;
            em_left    <= '0;
        end else if (!de_enable) begin
            wave_valid <= 1'b0;
            wave_value <= 1'b0;
            em_left    <= '0;
        end else if (hand) begin
            wave_valid <= 1'b1;
            wave_value <= div_level;
            em_left    <= 4'(quo);
        end else if (wave_valid && wave_ready) begin
            if (em_left == 4'd1)
                wave_valid <= 1'b0;
            em_left <= em_left - 1'b1;
        end
    end
endmodule

// File: tb/tb_point_judge_stream.sv
// tb/tb_point_judge_stream.sv - scoreboard bench for point_judge_stream
module tb_point_judge_stream;
    localparam int CW   = 12;
    localparam int MAXK = 4;
    localparam int WU   = 2;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          de_enable = 1'b0;
    logic          flag_edg_rise = 1'b0;
    logic          flag_edg_fall = 1'b0;
    logic [15:0]   threshold_peak = '0;
    logic [CW-1:0] cnt_point_ptr = 12'd10;
    logic          wave_ready = 1'b1;
    logic          edg_enable, edg_invalid, wave_valid, wave_value;
    logic          sym_overflow, seg_drop, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int inv_seen = 0, ovf_seen = 0, drop_seen = 0, pops = 0, ones = 0;
    bit sb[$];
    int m_warm = 0;
    bit m_pol = 1'b0;
    int m_last = 0;
    bit prev_stall = 1'b0;
    bit prev_val = 1'b0;

    point_judge_stream #(.ASK_WIDTH(16), .CNT_WIDTH(CW), .MAX_KEEP(MAXK), .WARMUP(WU)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .de_enable(de_enable),
        .flag_edg_rise(flag_edg_rise), .flag_edg_fall(flag_edg_fall),
        .threshold_peak(threshold_peak), .cnt_point_ptr(cnt_point_ptr),
        .wave_ready(wave_ready), .edg_enable(edg_enable), .edg_invalid(edg_invalid),
        .wave_valid(wave_valid), .wave_value(wave_value), .sym_overflow(sym_overflow),
        .seg_drop(seg_drop), .busy(busy)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        bit exp_v;
        if (rst_i) begin
            prev_stall = 1'b0;
        end else begin
            if (edg_invalid) inv_seen++;
            if (sym_overflow) ovf_seen++;
            if (seg_drop) drop_seen++;
            if (prev_stall) begin
                checks++;
                if (!wave_valid || wave_value !== prev_val) begin
                    errors++;
                    $display("FAIL stall_hold valid=%0b value=%0b required valid=1 value=%0b", wave_valid, wave_value, prev_val);
                end
            end
            if (wave_valid && wave_ready) begin
                checks++;
                pops++;
                if (wave_value) ones++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_symbol value=%0b required no symbol", wave_value);
                end else begin
                    exp_v = sb.pop_front();
                    if (wave_value !== exp_v) begin
                        errors++;
                        $display("FAIL symbol_value got %0b required %0b", wave_value, exp_v);
                    end
                end
            end
            prev_stall = wave_valid && !wave_ready;
            prev_val   = wave_value;
        end
    end

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic gap(input int g);
        repeat (g - 1) tick();
    endtask

    task automatic edge_ev(input bit is_rise, input bit keep);
        int l, n, p;
        threshold_peak = 16'($urandom);
        if (is_rise) flag_edg_rise = 1'b1; else flag_edg_fall = 1'b1;
        p = int'(cnt_point_ptr);
        if (m_warm < WU) begin
            m_warm++;
            m_pol  = is_rise;
            m_last = cyc;
        end else if (is_rise != m_pol) begin
            l = cyc - m_last;
            if (l > 4095) l = 4095;
            if (p != 0) begin
                n = (l + p / 2) / p;
                if (keep && n >= 1 && n <= MAXK)
                    repeat (n) sb.push_back(m_pol);
            end
            m_pol  = is_rise;
            m_last = cyc;
        end
        tick();
        flag_edg_rise = 1'b0;
        flag_edg_fall = 1'b0;
    endtask

    task automatic next_edge(input bit keep);
        edge_ev(!m_pol, keep);
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((sb.size() != 0 || busy) && k < 1000) begin
            @(negedge clk_i);
            k++;
        end
        checks++;
        if (sb.size() != 0 || busy) begin
            errors++;
            $display("FAIL %s_drain pending=%0d busy=%0b required 0 and 0", name, sb.size(), busy);
        end
        tick();
    endtask

    // clear the block, then warm up with rise, fall so the next edge is a rise
    task automatic resync();
        de_enable = 1'b0;
        tick();
        de_enable = 1'b1;
        sb.delete();
        m_warm = 0;
        edge_ev(1'b1, 1'b1);
        gap(2);
        edge_ev(1'b0, 1'b1);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        de_enable = 1'b0;
        repeat (2) tick();
        checks++;
        if ({edg_enable, edg_invalid, wave_valid, wave_value, sym_overflow, seg_drop, busy} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b required 0000000",
                     {edg_enable, edg_invalid, wave_valid, wave_value, sym_overflow, seg_drop, busy});
        end
        rst_i = 1'b0;
        tick();
        de_enable = 1'b1;
        m_warm = 0;
        repeat (3) tick();
        checks++;
        if (edg_enable !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle edg_enable=%0b busy=%0b required 0 0", edg_enable, busy);
        end
    endtask

    task automatic test_basic();
        int p0, o0;
        p0 = pops; o0 = ones;
        edge_ev(1'b1, 1'b1);
        checks++;
        if (edg_enable !== 1'b0) begin
            errors++;
            $display("FAIL warmup_first edg_enable=%0b required 0", edg_enable);
        end
        gap(2);
        edge_ev(1'b0, 1'b1);
        checks++;
        if (edg_enable !== 1'b1) begin
            errors++;
            $display("FAIL warmup_done edg_enable=%0b required 1", edg_enable);
        end
        gap(2);
        edge_ev(1'b1, 1'b1);
        gap(30);
        edge_ev(1'b0, 1'b1);
        gap(20);
        edge_ev(1'b1, 1'b1);
        wait_drain("basic");
        checks++;
        if (pops - p0 != 5 || ones - o0 != 3) begin
            errors++;
            $display("FAIL basic_counts symbols=%0d ones=%0d required 5 3", pops - p0, ones - o0);
        end
    endtask

    task automatic test_rounding();
        int p0, o0, v0, i0;
        resync();
        p0 = pops; o0 = ones; v0 = ovf_seen; i0 = inv_seen;
        gap(24); next_edge(1'b1);
        gap(25); next_edge(1'b1);
        gap(4);  next_edge(1'b1);
        wait_drain("rounding");
        checks++;
        if (pops - p0 != 5 || ones - o0 != 3) begin
            errors++;
            $display("FAIL rounding_counts symbols=%0d ones=%0d required 5 3", pops - p0, ones - o0);
        end
        checks++;
        if (ovf_seen != v0 || inv_seen != i0) begin
            errors++;
            $display("FAIL rounding_flags overflow=%0d invalid=%0d required 0 0", ovf_seen - v0, inv_seen - i0);
        end
    endtask

    task automatic test_duplicate();
        int p0, o0, i0;
        resync();
        p0 = pops; o0 = ones; i0 = inv_seen;
        gap(10); edge_ev(1'b1, 1'b1);
        gap(12); edge_ev(1'b1, 1'b1);
        gap(18); edge_ev(1'b0, 1'b1);
        wait_drain("duplicate");
        checks++;
        if (inv_seen - i0 != 1) begin
            errors++;
            $display("FAIL duplicate_invalid pulses=%0d required 1", inv_seen - i0);
        end
        checks++;
        if (pops - p0 != 4 || ones - o0 != 3) begin
            errors++;
            $display("FAIL duplicate_counts symbols=%0d ones=%0d required 4 3", pops - p0, ones - o0);
        end
    endtask

    task automatic test_simultaneous();
        int i0, p0;
        i0 = inv_seen; p0 = pops;
        flag_edg_rise = 1'b1;
        flag_edg_fall = 1'b1;
        tick();
        flag_edg_rise = 1'b0;
        flag_edg_fall = 1'b0;
        repeat (20) tick();
        checks++;
        if (inv_seen - i0 != 1 || pops != p0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL simultaneous invalid=%0d symbols=%0d busy=%0b required 1 0 0", inv_seen - i0, pops - p0, busy);
        end
    endtask

    task automatic test_overflow();
        int v0, p0;
        resync();
        v0 = ovf_seen; p0 = pops;
        gap(60); next_edge(1'b1);
        wait_drain("overflow_l60");
        cnt_point_ptr = '0;
        gap(20); next_edge(1'b1);
        cnt_point_ptr = 12'd10;
        wait_drain("overflow_p0");
        checks++;
        if (ovf_seen - v0 != 2 || pops != p0) begin
            errors++;
            $display("FAIL overflow pulses=%0d symbols=%0d required 2 0", ovf_seen - v0, pops - p0);
        end
    endtask

    task automatic test_back_to_back();
        int d0, p0, o0;
        resync();
        d0 = drop_seen; p0 = pops; o0 = ones;
        wave_ready = 1'b0;
        repeat (3) begin gap(20); next_edge(1'b1); end
        gap(20); next_edge(1'b0);
        repeat (3) tick();
        checks++;
        if (drop_seen - d0 != 1) begin
            errors++;
            $display("FAIL seg_drop pulses=%0d required 1", drop_seen - d0);
        end
        checks++;
        if (wave_valid !== 1'b1 || busy !== 1'b1 || pops != p0) begin
            errors++;
            $display("FAIL stalled_state valid=%0b busy=%0b symbols=%0d required 1 1 0", wave_valid, busy, pops - p0);
        end
        wave_ready = 1'b1;
        wait_drain("back_to_back");
        checks++;
        if (pops - p0 != 6 || ones - o0 != 2) begin
            errors++;
            $display("FAIL back_to_back_counts symbols=%0d ones=%0d required 6 2", pops - p0, ones - o0);
        end
    endtask

    task automatic test_reset_mid();
        int k, p0;
        resync();
        p0 = pops;
        wave_ready = 1'b0;
        gap(30); next_edge(1'b1);
        k = 0;
        while (!wave_valid && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        checks++;
        if (!wave_valid) begin
            errors++;
            $display("FAIL reset_mid_wait valid=%0b required 1", wave_valid);
        end
        tick();
        wave_ready = 1'b1;
        repeat (2) tick();
        wave_ready = 1'b0;
        rst_i = 1'b1;
        #1;
        checks++;
        if (wave_valid !== 1'b0 || busy !== 1'b0 || pops - p0 != 2) begin
            errors++;
            $display("FAIL reset_mid valid=%0b busy=%0b sent=%0d required 0 0 2", wave_valid, busy, pops - p0);
        end
        sb.delete();
        m_warm = 0;
        wave_ready = 1'b1;
        repeat (2) tick();
        rst_i = 1'b0;
        tick();
        p0 = pops;
        edge_ev(1'b1, 1'b1);
        checks++;
        if (edg_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_warm_first edg_enable=%0b required 0", edg_enable);
        end
        gap(30);
        edge_ev(1'b0, 1'b1);
        checks++;
        if (edg_enable !== 1'b1) begin
            errors++;
            $display("FAIL reset_warm_second edg_enable=%0b required 1", edg_enable);
        end
        repeat (20) tick();
        checks++;
        if (pops != p0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_warm_quiet symbols=%0d busy=%0b required 0 0", pops - p0, busy);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_duplicate();
        test_simultaneous();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
